// File: rtl/snn_pkg.sv
// Shared FSM encodings and width helpers for the spiking window classifier.
// Widths are derived from the instance parameters through these functions.
package snn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_ARGMAX = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // A vector always needs at least one bit, even for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_width(input int n_in, input int n_hid, input int n_out);
    return clog2_min1(n_in * n_hid + n_hid * n_out);
  endfunction

  function automatic int cur_width(input int wp, input int n_src);
    return wp + $clog2(n_src + 1);
  endfunction

  function automatic int out_base(input int n_in, input int n_hid);
    return n_in * n_hid;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with a saturating membrane and an adaptive
// threshold that rises on each spike and decays back toward a floor.
module lif_neuron #(
  parameter int MEM_W         = 8,
  parameter int CUR_W         = 7,
  parameter int LEAK_SHIFT    = 3,
  parameter int THRESHOLD     = 16,
  parameter int THRESHOLD_INC = 2,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 8,
  parameter int THRESHOLD_MAX = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CUR_W-1:0] current_i,
  output logic             spike_o
);

  localparam int SUM_W = ((MEM_W > CUR_W) ? MEM_W : CUR_W) + 1;
  localparam logic [SUM_W-1:0] V_SAT     = SUM_W'({MEM_W{1'b1}});
  localparam logic [MEM_W-1:0] THR_INIT  = MEM_W'(THRESHOLD);
  localparam logic [MEM_W:0]   THR_MAX_V = (MEM_W+1)'(THRESHOLD_MAX);
  localparam logic [MEM_W:0]   THR_LOW_V = (MEM_W+1)'(THRESHOLD_MIN + THRESHOLD_DEC);

  logic [MEM_W-1:0] v_q, thr_q, v_next, thr_hi, thr_lo;
  logic [SUM_W-1:0] v_sum;
  logic [MEM_W:0]   thr_inc;
  logic             fire;

  always_comb begin
    v_sum   = SUM_W'(v_q - (v_q >> LEAK_SHIFT)) + SUM_W'(current_i);
    v_next  = (v_sum > V_SAT) ? {MEM_W{1'b1}} : v_sum[MEM_W-1:0];
    fire    = (v_next >= thr_q);
    thr_inc = {1'b0, thr_q} + (MEM_W+1)'(THRESHOLD_INC);
    thr_hi  = (thr_inc > THR_MAX_V) ? THR_MAX_V[MEM_W-1:0] : thr_inc[MEM_W-1:0];
    thr_lo  = ({1'b0, thr_q} < THR_LOW_V) ? MEM_W'(THRESHOLD_MIN)
                                          : thr_q - MEM_W'(THRESHOLD_DEC);
  end

  assign spike_o = en_i & fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= '0;
      thr_q <= THR_INIT;
    end else if (clear_i) begin
      v_q   <= '0;
      thr_q <= THR_INIT;
    end else if (en_i) begin
      if (fire) begin
        v_q   <= '0;
        thr_q <= thr_hi;
      end else begin
        v_q   <= v_next;
        thr_q <= thr_lo;
      end
    end
  end

endmodule

// File: rtl/snn_window_classifier.sv
// Two-layer LIF spiking classifier: integrates input spikes over a fixed window,
// counts output spikes per class, then scans the counters for the winner.
module snn_window_classifier
  import snn_pkg::*;
#(
  parameter int NUM_IN        = 8,
  parameter int NUM_HID       = 4,
  parameter int NUM_OUT       = 10,
  parameter int WIDTH_P       = 3,
  parameter int MEM_W         = 8,
  parameter int CNT_W         = 8,
  parameter int WINDOW        = 64,
  parameter int LEAK_SHIFT    = 3,
  parameter int THRESHOLD     = 16,
  parameter int THRESHOLD_INC = 2,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 8,
  parameter int THRESHOLD_MAX = 64
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           start_i,
  input  logic                                           abort_i,
  input  logic [NUM_IN-1:0]                              in_spike_i,
  input  logic                                           wr_en_i,
  input  logic [addr_width(NUM_IN, NUM_HID, NUM_OUT)-1:0] wr_addr_i,
  input  logic [WIDTH_P-1:0]                             wr_data_i,
  output logic                                           busy_o,
  output logic                                           valid_o,
  output logic [clog2_min1(NUM_OUT)-1:0]                 predicted_o,
  output logic [CNT_W-1:0]                               max_count_o,
  output logic                                           tie_o
);

  localparam int ADDR_W    = addr_width(NUM_IN, NUM_HID, NUM_OUT);
  localparam int CLS_W     = clog2_min1(NUM_OUT);
  localparam int WIN_W     = clog2_min1(WINDOW);
  localparam int HID_CUR_W = cur_width(WIDTH_P, NUM_IN);
  localparam int OUT_CUR_W = cur_width(WIDTH_P, NUM_HID);
  localparam int OUT_BASE  = out_base(NUM_IN, NUM_HID);
  localparam int NUM_SYN   = OUT_BASE + NUM_HID * NUM_OUT;

  localparam logic [ADDR_W:0]  NUM_SYN_V = (ADDR_W+1)'(NUM_SYN);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [CLS_W-1:0] IDX_LAST  = CLS_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [WIDTH_P-1:0]   weight_q [NUM_SYN];
  logic [2:0]           state_q;
  logic [WIN_W-1:0]     cyc_q;
  logic [CLS_W-1:0]     idx_q, best_idx_q;
  logic [CNT_W-1:0]     best_cnt_q;
  logic                 best_tie_q;
  logic [CNT_W-1:0]     count_q [NUM_OUT];
  logic [NUM_HID-1:0]   hid_spike, hid_spike_q;
  logic [NUM_OUT-1:0]   out_spike;
  logic [NUM_IN-1:0]    in_gated;
  logic [HID_CUR_W-1:0] hid_cur [NUM_HID];
  logic [OUT_CUR_W-1:0] out_cur [NUM_OUT];
  logic                 neuron_en, neuron_clr, wr_ok;

  assign busy_o     = (state_q != ST_IDLE);
  assign neuron_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign neuron_clr = (state_q == ST_IDLE) && start_i;
  assign in_gated   = (state_q == ST_RUN) ? in_spike_i : '0;
  assign wr_ok      = wr_en_i && !busy_o && ({1'b0, wr_addr_i} < NUM_SYN_V);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SYN; s++) weight_q[s] <= '0;
    end else if (wr_ok) begin
      weight_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Synapse a = hid*NUM_IN + in for layer 1; OUT_BASE + out*NUM_HID + hid for layer 2.
  always_comb begin
    for (int j = 0; j < NUM_HID; j++) begin
      hid_cur[j] = '0;
      for (int i = 0; i < NUM_IN; i++)
        if (in_gated[i]) hid_cur[j] = hid_cur[j] + HID_CUR_W'(weight_q[j*NUM_IN + i]);
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out_cur[k] = '0;
      for (int j = 0; j < NUM_HID; j++)
        if (hid_spike_q[j]) out_cur[k] = out_cur[k] + OUT_CUR_W'(weight_q[OUT_BASE + k*NUM_HID + j]);
    end
  end

  for (genvar j = 0; j < NUM_HID; j++) begin : g_hid
    lif_neuron #(
      .MEM_W(MEM_W), .CUR_W(HID_CUR_W), .LEAK_SHIFT(LEAK_SHIFT),
      .THRESHOLD(THRESHOLD), .THRESHOLD_INC(THRESHOLD_INC), .THRESHOLD_DEC(THRESHOLD_DEC),
      .THRESHOLD_MIN(THRESHOLD_MIN), .THRESHOLD_MAX(THRESHOLD_MAX)
    ) u_lif (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(neuron_clr), .en_i(neuron_en),
      .current_i(hid_cur[j]), .spike_o(hid_spike[j])
    );
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    lif_neuron #(
      .MEM_W(MEM_W), .CUR_W(OUT_CUR_W), .LEAK_SHIFT(LEAK_SHIFT),
      .THRESHOLD(THRESHOLD), .THRESHOLD_INC(THRESHOLD_INC), .THRESHOLD_DEC(THRESHOLD_DEC),
      .THRESHOLD_MIN(THRESHOLD_MIN), .THRESHOLD_MAX(THRESHOLD_MAX)
    ) u_lif (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(neuron_clr), .en_i(neuron_en),
      .current_i(out_cur[k]), .spike_o(out_spike[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hid_spike_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) count_q[k] <= '0;
    end else if (neuron_clr) begin
      hid_spike_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) count_q[k] <= '0;
    end else if (neuron_en) begin
      hid_spike_q <= hid_spike;
      for (int k = 0; k < NUM_OUT; k++)
        if (out_spike[k] && count_q[k] != CNT_MAX) count_q[k] <= count_q[k] + 1'b1;
    end
  end

  // Counters settle on the DRAIN edge, so the scan's running best starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      best_tie_q  <= 1'b0;
      valid_o     <= 1'b0;
      predicted_o <= '0;
      max_count_o <= '0;
      tie_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (abort_i && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_RUN;
              cyc_q   <= '0;
            end
          end
          ST_RUN: begin
            if (cyc_q == WIN_LAST) state_q <= ST_DRAIN;
            else                   cyc_q   <= cyc_q + 1'b1;
          end
          ST_DRAIN: begin
            state_q    <= ST_ARGMAX;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            best_tie_q <= 1'b0;
          end
          ST_ARGMAX: begin
            if (count_q[idx_q] > best_cnt_q) begin
              best_cnt_q <= count_q[idx_q];
              best_idx_q <= idx_q;
              best_tie_q <= 1'b0;
            end else if (count_q[idx_q] == best_cnt_q && idx_q != best_idx_q) begin
              best_tie_q <= 1'b1;
            end
            if (idx_q == IDX_LAST) state_q <= ST_DONE;
            else                   idx_q   <= idx_q + 1'b1;
          end
          ST_DONE: begin
            valid_o     <= 1'b1;
            predicted_o <= best_idx_q;
            max_count_o <= best_cnt_q;
            tie_o       <= best_tie_q;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_window_classifier.sv
// Scoreboard bench: a cycle-level network model predicts each inference result,
// monitors pop and compare whenever a DUT raises valid_o.
module tb_snn_window_classifier;

  localparam int NUM_IN  = 8;
  localparam int NUM_HID = 4;
  localparam int NUM_OUT = 10;
  localparam int WINDOW  = 64;
  localparam int WINDOW2 = 200;
  localparam int ADDR_W  = 7;
  localparam int N_HSYN  = NUM_IN * NUM_HID;
  localparam int NUM_SYN = N_HSYN + NUM_HID * NUM_OUT;

  typedef struct {
    int pred;
    int mx;
    int tie;
    int due;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0, abort_i = 1'b0, wr_en_i = 1'b0;
  logic [NUM_IN-1:0] in_spike_i = '0;
  logic [ADDR_W-1:0] wr_addr_i = '0;
  logic [2:0]        wr_data_i = '0;
  logic              busy_o, valid_o, tie_o;
  logic [3:0]        predicted_o;
  logic [7:0]        max_count_o;

  logic              start2 = 1'b0, abort2 = 1'b0, wr_en2 = 1'b0;
  logic [NUM_IN-1:0] in_spike2 = '0;
  logic              busy2, valid2, tie2;
  logic [3:0]        pred2, max2;

  int   w_h [NUM_IN][NUM_HID];
  int   w_o [NUM_HID][NUM_OUT];
  exp_t sb_q[$], sb2_q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   last_pred = 0, last_max = 0, last_tie = 0;

  snn_window_classifier u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .in_spike_i(in_spike_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .valid_o(valid_o), .predicted_o(predicted_o),
    .max_count_o(max_count_o), .tie_o(tie_o)
  );

  snn_window_classifier #(.CNT_W(4), .WINDOW(WINDOW2)) u_dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start2), .abort_i(abort2),
    .in_spike_i(in_spike2), .wr_en_i(wr_en2), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .busy_o(busy2), .valid_o(valid2), .predicted_o(pred2),
    .max_count_o(max2), .tie_o(tie2)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit lif_step(inout int v, inout int thr, input int cur);
    int vp;
    vp = v - (v >> 3) + cur;
    if (vp > 255) vp = 255;
    if (vp >= thr) begin
      v = 0;
      thr = (thr + 2 > 64) ? 64 : thr + 2;
      return 1'b1;
    end
    v = vp;
    thr = (thr - 1 < 8) ? 8 : thr - 1;
    return 1'b0;
  endfunction

  // One step per RUN cycle plus a final drain step with no input; output layer sees last step's hidden spikes.
  function automatic void model(input logic [NUM_IN-1:0] sp[$], input int cnt_max,
                                output int pred, output int mx, output int tie);
    int hv[NUM_HID], ht[NUM_HID], ov[NUM_OUT], ot[NUM_OUT], cnt[NUM_OUT];
    bit hq[NUM_HID], hs[NUM_HID];
    int cur, n;
    for (int j = 0; j < NUM_HID; j++) begin hv[j] = 0; ht[j] = 16; hq[j] = 0; end
    for (int k = 0; k < NUM_OUT; k++) begin ov[k] = 0; ot[k] = 16; cnt[k] = 0; end
    for (int c = 0; c <= sp.size(); c++) begin
      for (int j = 0; j < NUM_HID; j++) begin
        cur = 0;
        if (c < sp.size())
          for (int i = 0; i < NUM_IN; i++) if (sp[c][i]) cur += w_h[i][j];
        hs[j] = lif_step(hv[j], ht[j], cur);
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        cur = 0;
        for (int j = 0; j < NUM_HID; j++) if (hq[j]) cur += w_o[j][k];
        if (lif_step(ov[k], ot[k], cur) && cnt[k] < cnt_max) cnt[k]++;
      end
      hq = hs;
    end
    mx = 0; pred = 0; n = 0;
    for (int k = 0; k < NUM_OUT; k++) if (cnt[k] > mx) begin mx = cnt[k]; pred = k; end
    for (int k = 0; k < NUM_OUT; k++) if (cnt[k] == mx) n++;
    tie = (n > 1) ? 1 : 0;
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && valid_o) begin
      if (sb_q.size() == 0) checkOutput("unexpected_valid", 1, 0);
      else begin
        e = sb_q.pop_front();
        checkOutput("predicted", int'(predicted_o), e.pred);
        checkOutput("max_count", int'(max_count_o), e.mx);
        checkOutput("tie", int'(tie_o), e.tie);
        checkOutput("valid_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && valid2) begin
      if (sb2_q.size() == 0) checkOutput("sat_unexpected_valid", 1, 0);
      else begin
        e = sb2_q.pop_front();
        checkOutput("sat_predicted", int'(pred2), e.pred);
        checkOutput("sat_max_count", int'(max2), e.mx);
        checkOutput("sat_tie", int'(tie2), e.tie);
        checkOutput("sat_latency", cyc, e.due);
      end
    end
  end

  task automatic write_weight(input int a, input int d);
    int b;
    @(negedge clk_i);
    wr_en_i = 1'b1; wr_en2 = 1'b1;
    wr_addr_i = ADDR_W'(a); wr_data_i = 3'(d);
    if (a < N_HSYN) w_h[a % NUM_IN][a / NUM_IN] = d;
    else if (a < NUM_SYN) begin
      b = a - N_HSYN;
      w_o[b % NUM_HID][b / NUM_HID] = d;
    end
    @(negedge clk_i);
    wr_en_i = 1'b0; wr_en2 = 1'b0;
  endtask

  // pattern: 0 zero, 1 class 3, 2 classes 2 and 5, 3 random, 4 class 4
  task automatic set_weights(input int pattern);
    int d, k;
    for (int a = 0; a < NUM_SYN; a++) begin
      k = (a - N_HSYN) / NUM_HID;
      if (pattern == 3) d = int'($urandom_range(7));
      else if (a < N_HSYN) d = (pattern == 0) ? 0 : 7;
      else if (pattern == 1) d = (k == 3) ? 7 : 0;
      else if (pattern == 2) d = (k == 2 || k == 5) ? 7 : 0;
      else if (pattern == 4) d = (k == 4) ? 7 : 0;
      else d = 0;
      write_weight(a, d);
    end
  endtask

  // mode: 0 normal, 1 busy write + start mid-run, 2 abort at cycle 10, 3 reset at cycle 10
  task automatic applyStimulus(input int mode, input int density);
    logic [NUM_IN-1:0] sp[$];
    logic [NUM_IN-1:0] v;
    int p, m, tie_e, waited;
    for (int t = 0; t < WINDOW; t++) begin
      for (int i = 0; i < NUM_IN; i++) v[i] = (int'($urandom_range(99)) < density);
      sp.push_back(v);
    end
    model(sp, 255, p, m, tie_e);
    @(negedge clk_i);
    start_i = 1'b1;
    if (mode <= 1) sb_q.push_back(exp_t'{p, m, tie_e, cyc + WINDOW + NUM_OUT + 3});
    for (int c = 0; c < WINDOW; c++) begin
      @(negedge clk_i);
      start_i = 1'b0; wr_en_i = 1'b0; in_spike_i = sp[c];
      if (mode == 1 && c == 5) begin
        start_i = 1'b1; wr_en_i = 1'b1;
        wr_addr_i = '0; wr_data_i = 3'(~w_h[0][0]);
      end
      if (mode == 2 && c == 10) begin
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0; in_spike_i = '0;
        checkOutput("abort_busy", int'(busy_o), 0);
        checkOutput("abort_no_valid", int'(valid_o), 0);
        checkOutput("abort_held_pred", int'(predicted_o), last_pred);
        checkOutput("abort_held_max", int'(max_count_o), last_max);
        checkOutput("abort_held_tie", int'(tie_o), last_tie);
        return;
      end
      if (mode == 3 && c == 10) begin
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy_o), 0);
        checkOutput("rst_valid", int'(valid_o), 0);
        checkOutput("rst_pred", int'(predicted_o), 0);
        checkOutput("rst_max", int'(max_count_o), 0);
        checkOutput("rst_tie", int'(tie_o), 0);
        for (int i = 0; i < NUM_IN; i++) for (int j = 0; j < NUM_HID; j++) w_h[i][j] = 0;
        for (int j = 0; j < NUM_HID; j++) for (int k = 0; k < NUM_OUT; k++) w_o[j][k] = 0;
        last_pred = 0; last_max = 0; last_tie = 0;
        @(negedge clk_i);
        rst_ni = 1'b1; in_spike_i = '0;
        return;
      end
    end
    @(negedge clk_i);
    in_spike_i = '0;
    waited = 0;
    while (busy_o && waited < WINDOW + NUM_OUT + 10) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("run_completes", int'(busy_o), 0);
    last_pred = p; last_max = m; last_tie = tie_e;
    @(negedge clk_i);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_IN-1:0] sp2[$];
    int p, m, tie_e, waited;
    for (int i = 0; i < NUM_IN; i++) for (int j = 0; j < NUM_HID; j++) w_h[i][j] = 0;
    for (int j = 0; j < NUM_HID; j++) for (int k = 0; k < NUM_OUT; k++) w_o[j][k] = 0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_valid", int'(valid_o), 0);
    checkOutput("reset_pred", int'(predicted_o), 0);
    checkOutput("reset_max", int'(max_count_o), 0);
    checkOutput("reset_tie", int'(tie_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("[TB] zero weights, all inputs active");
    applyStimulus(0, 100);
    checkOutput("zero_tie", int'(tie_o), 1);

    $display("[TB] single class 3 path");
    set_weights(1);
    write_weight(100, 5);
    applyStimulus(0, 100);
    checkOutput("class3_pred", int'(predicted_o), 3);
    checkOutput("class3_nonzero", int'(max_count_o > 0), 1);
    checkOutput("class3_tie", int'(tie_o), 0);

    $display("[TB] classes 2 and 5 tied");
    set_weights(2);
    applyStimulus(0, 100);
    checkOutput("tie25_pred", int'(predicted_o), 2);
    checkOutput("tie25_tie", int'(tie_o), 1);

    $display("[TB] random weights and densities");
    for (int r = 0; r < 4; r++) begin
      set_weights(3);
      applyStimulus(0, int'($urandom_range(20, 90)));
    end

    $display("[TB] busy write and mid-run start, then baseline");
    applyStimulus(1, 60);
    applyStimulus(0, 60);

    $display("[TB] abort then fresh run");
    applyStimulus(2, 70);
    applyStimulus(0, 70);

    $display("[TB] reset mid-run then fresh run");
    applyStimulus(3, 70);
    applyStimulus(0, 100);

    $display("[TB] counter saturation on narrow-counter instance");
    set_weights(4);
    for (int t = 0; t < WINDOW2; t++) sp2.push_back('1);
    model(sp2, 15, p, m, tie_e);
    @(negedge clk_i);
    start2 = 1'b1;
    sb2_q.push_back(exp_t'{p, m, tie_e, cyc + WINDOW2 + NUM_OUT + 3});
    @(negedge clk_i);
    start2 = 1'b0; in_spike2 = '1;
    waited = 0;
    while (busy2 && waited < WINDOW2 + NUM_OUT + 10) begin
      @(negedge clk_i);
      waited++;
    end
    in_spike2 = '0;
    checkOutput("sat_completes", int'(busy2), 0);
    checkOutput("sat_max_is_15", int'(max2), 15);
    repeat (3) @(negedge clk_i);

    checkOutput("pending_results", sb_q.size() + sb2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
